// File: rtl/data_memory_arbiter.sv
// Shares one data RAM port between the core load/store unit and the loader.
// Optional grant/starvation statistics are built when ARB_STATS_EN is defined.
module data_memory_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    input  logic                  ldr_lock,
    output logic                  ldr_gnt,
    output logic                  ldr_rvalid,
    output logic [DATA_WIDTH-1:0] ldr_rdata,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]           cpu_gnt_count,
    output logic [15:0]           ldr_gnt_count,
    output logic [7:0]            starve_event_count
`endif
);

    localparam logic [3:0] SL = 4'(STARVE_LIMIT);
    localparam logic [7:0] LM = 8'(LOCK_MAX);

    typedef enum logic [1:0] {IDLE, LDR_LOCK, CPU_FAIR} state_t;

    state_t     r_state;
    logic [3:0] r_starve_cnt;
    logic [7:0] r_lock_cnt;
    logic       r_cpu_rvalid;
    logic       r_ldr_rvalid;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_ldr_rdata;

    logic w_starved;
    logic w_cpu_win;
    logic w_ldr_win;
    logic w_lock_last;

    assign w_starved   = (r_starve_cnt == SL);
    assign w_lock_last = (r_lock_cnt == LM - 8'd1);

    always_comb begin
        w_cpu_win = 1'b0;
        w_ldr_win = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (ldr_req && w_starved) w_ldr_win = 1'b1;
                else if (cpu_req)         w_cpu_win = 1'b1;
                else if (ldr_req)         w_ldr_win = 1'b1;
            end
            LDR_LOCK: w_ldr_win = ldr_req;
            CPU_FAIR: begin
                if (cpu_req) w_cpu_win = 1'b1;
                else         w_ldr_win = ldr_req;
            end
            default: ;
        endcase
        // Reset silences every output immediately, not just at the next edge
        if (reset) begin
            w_cpu_win = 1'b0;
            w_ldr_win = 1'b0;
        end
    end

    assign cpu_gnt    = w_cpu_win;
    assign ldr_gnt    = w_ldr_win;
    assign cpu_stall  = cpu_req & ~w_cpu_win & ~reset;
    assign cpu_rvalid = r_cpu_rvalid;
    assign ldr_rvalid = r_ldr_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign ldr_rdata  = r_ldr_rdata;

    assign mem_we    = (w_cpu_win & cpu_we) | (w_ldr_win & ldr_we);
    assign mem_re    = (w_cpu_win & ~cpu_we) | (w_ldr_win & ~ldr_we);
    assign mem_addr  = w_cpu_win ? cpu_addr  : (w_ldr_win ? ldr_addr  : '0);
    assign mem_wdata = w_cpu_win ? cpu_wdata : (w_ldr_win ? ldr_wdata : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_lock_cnt   <= '0;
        end else begin
            if (w_ldr_win)
                r_starve_cnt <= '0;
            else if (ldr_req && !w_starved)
                r_starve_cnt <= r_starve_cnt + 4'd1;

            unique case (r_state)
                IDLE: begin
                    if (w_ldr_win && ldr_lock) begin
                        r_state    <= (LM == 8'd1) ? CPU_FAIR : LDR_LOCK;
                        r_lock_cnt <= 8'd1;
                    end
                end
                LDR_LOCK: begin
                    if (!ldr_lock || !ldr_req) begin
                        r_state    <= IDLE;
                        r_lock_cnt <= '0;
                    end else if (w_lock_last) begin
                        r_state    <= CPU_FAIR;
                        r_lock_cnt <= '0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 8'd1;
                    end
                end
                CPU_FAIR: begin
                    r_state    <= IDLE;
                    r_lock_cnt <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_rvalid <= 1'b0;
            r_ldr_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_ldr_rdata  <= '0;
        end else begin
            r_cpu_rvalid <= w_cpu_win & ~cpu_we;
            r_ldr_rvalid <= w_ldr_win & ~ldr_we;
            if (w_cpu_win && !cpu_we) r_cpu_rdata <= mem_rdata;
            if (w_ldr_win && !ldr_we) r_ldr_rdata <= mem_rdata;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] r_cpu_gnt_count;
    logic [15:0] r_ldr_gnt_count;
    logic [7:0]  r_starve_event_count;
    logic        w_starve_hit;

    assign w_starve_hit = ldr_req & ~w_ldr_win & (r_starve_cnt == SL - 4'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_gnt_count      <= '0;
            r_ldr_gnt_count      <= '0;
            r_starve_event_count <= '0;
        end else begin
            if (w_cpu_win && r_cpu_gnt_count != 16'hFFFF)
                r_cpu_gnt_count <= r_cpu_gnt_count + 16'd1;
            if (w_ldr_win && r_ldr_gnt_count != 16'hFFFF)
                r_ldr_gnt_count <= r_ldr_gnt_count + 16'd1;
            if (w_starve_hit && r_starve_event_count != 8'hFF)
                r_starve_event_count <= r_starve_event_count + 8'd1;
        end
    end

    assign cpu_gnt_count      = r_cpu_gnt_count;
    assign ldr_gnt_count      = r_ldr_gnt_count;
    assign starve_event_count = r_starve_event_count;
`endif

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single-port data RAM between the MIPS core's load/store port and a second requester, the program/data loader used for boot and debug.
- Fixed CPU priority with a starvation guard for the loader, plus a loader lock mode for bursts.
- Registers read data and returns it to the winning requester with 1-cycle latency.
- Sits between the core's data-memory interface and the DataMemory RAM instance.

Parameters:
- DATA_WIDTH, 32, width of data buses.
- ADDR_WIDTH, 32, width of address buses.
- STARVE_LIMIT, 4, consecutive denied loader cycles before the loader overrides the CPU; 1..15.
- LOCK_MAX, 8, maximum consecutive locked loader grants before forced release; 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cpu_req  input  1  CPU access request, held until granted.
- cpu_we  input  1  1=write, 0=read.
- cpu_addr  input  ADDR_WIDTH  CPU byte address.
- cpu_wdata  input  DATA_WIDTH  CPU write data.
- cpu_gnt  output  1  CPU access accepted this cycle.
- cpu_stall  output  1  cpu_req & ~cpu_gnt.
- cpu_rvalid  output  1  CPU read data valid.
- cpu_rdata  output  DATA_WIDTH  CPU read data.
- ldr_req, ldr_we, ldr_addr, ldr_wdata  inputs  same meaning for the loader.
- ldr_lock  input  1  loader requests burst ownership.
- ldr_gnt, ldr_rvalid, ldr_rdata  outputs  same meaning for the loader.
- mem_we  output  1  RAM write enable.
- mem_re  output  1  RAM read enable.
- mem_addr  output  ADDR_WIDTH  RAM address.
- mem_wdata  output  DATA_WIDTH  RAM write data.
- mem_rdata  input  DATA_WIDTH  RAM combinational read data.

Behaviour:
- Reset forces the following, taking effect immediately:
  - all outputs 0;
  - state = IDLE;
  - starve_cnt = 0, lock_cnt = 0;
  - any pending read return is discarded (no rvalid after reset).
- Arbitration is combinational from the registered state and the current requests. At most one gnt is high per cycle.
- mem_* are driven from the winner in the grant cycle. With no grant, mem_we = mem_re = 0 and mem_addr/mem_wdata = 0.
- A read grant captures mem_rdata into the winner's rdata register at the clock edge. The matching rvalid is high for exactly the next cycle. rdata holds its value until the next read return.
- A write grant produces no rvalid.
- States:
  - IDLE:
    - ldr_req & starve_cnt==STARVE_LIMIT -> grant loader;
    - else cpu_req -> grant CPU;
    - else ldr_req -> grant loader.
    - A loader grant with ldr_lock=1 moves to LDR_LOCK (lock_cnt=1). Otherwise stay in IDLE.
  - LDR_LOCK:
    - Loader only; the CPU is denied.
    - Each loader grant increments lock_cnt.
    - ldr_lock=0 or ldr_req=0 -> IDLE.
    - lock_cnt==LOCK_MAX at a grant -> CPU_FAIR.
  - CPU_FAIR:
    - CPU wins if cpu_req, regardless of starve_cnt. Loader wins only if cpu_req=0.
    - Always returns to IDLE next cycle. Guarantees the CPU one slot after a forced release.
- starve_cnt:
  - increments, saturating at STARVE_LIMIT, each cycle ldr_req=1 and ldr_gnt=0;
  - clears on ldr_gnt;
  - holds when ldr_req=0.
- Simultaneous cpu_req & ldr_req in IDLE with starve_cnt<STARVE_LIMIT -> CPU wins; starve_cnt increments.
- Requests are level-held. Address/we/wdata must be stable while req=1. A deasserted req is simply dropped; no error is raised.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, adds three outputs, all cleared by reset:
  - cpu_gnt_count [15:0], saturating at 16'hFFFF;
  - ldr_gnt_count [15:0], saturating at 16'hFFFF;
  - starve_event_count [7:0], incremented each time starve_cnt reaches STARVE_LIMIT, saturating.
- When not defined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- CPU read, loader idle: cpu_req=1, cpu_we=0, cpu_addr=0x10, mem_rdata=0xDEADBEEF -> cpu_gnt=1, mem_re=1, mem_addr=0x10 the same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF.
- Contention: both requests held continuously, STARVE_LIMIT=4 -> CPU granted cycles 0-3, loader granted cycle 4, starve_cnt=0, CPU granted cycle 5.
- Lock burst: LOCK_MAX=8, ldr_lock=1, ldr_req=1, cpu_req=1 from the start:
  - Cycle 0: CPU wins (starve_cnt=0 < STARVE_LIMIT); loader starves cycles 0-3 and is granted in cycle 4 via the starvation override, entering LDR_LOCK (lock_cnt=1).
  - Cycles 4-11: 8 consecutive loader grants; cpu_stall=1 throughout.
  - Cycle 12 (CPU_FAIR): CPU granted.
- Lock early release: ldr_lock drops after 3 locked grants -> IDLE next cycle; CPU granted if requesting.
- Loader write 0x000000A5 to 0x20 -> mem_we=1, mem_wdata=0xA5, ldr_gnt=1; no ldr_rvalid follows.
- Reset mid-read: assert reset in the cycle after a CPU read grant -> cpu_rvalid=0; all outputs 0; first post-reset contention goes to the CPU.
